rfid_link_hub: RTL and testbench
================================

# rfid_link_hub

Parametrised air-link hub for the RFID system bench. It sits between one reader/antenna model and `NUM_TAGS` tag instances, replacing the single point-to-point reader/tag wiring. It broadcasts the reader line to every enabled tag and merges the tag backscatter lines into one reply line with owner arbitration and collision detection. It also drives per-command status LEDs with a programmable hold time and keeps reply and collision statistics.

## Interface
Parameters:
- `NUM_TAGS`, 4: number of tag channels, from 1 to 16.
- `LED_HOLD`, 25_000_000: number of cycles an LED stays lit after a trigger (0.5 s at 50 MHz).
- `IDLE_TIMEOUT`, 64: number of quiet cycles (no edge on the owner line) that end a reply window.
- `LISTEN_MAX`, 4096: number of cycles to wait for a first reply before declaring no reply.

Ports:
- `clk_50m`, in, 1: system clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `rd_data`, in, 1: reader transmit line; idle level is 0.
- `cmd_vld`, in, 1: one-cycle strobe marking the end of a reader command.
- `cmd_code`, in, 3: command class qualified by `cmd_vld`: 0 sort, 1 query, 2 ack, 3 read, 4 write, 5–7 reserved.
- `tag_en`, in, NUM_TAGS: per-tag enable mask.
- `tag_dout`, in, NUM_TAGS: tag backscatter lines; idle level is 0.
- `tag_din`, out, NUM_TAGS: per-tag gated copy of `rd_data`.
- `tag_data`, out, 1: merged reply line to the reader.
- `owner`, out, clog2(NUM_TAGS) (minimum 1): index of the tag that currently owns the reply.
- `collision`, out, 1: sticky flag set when a second enabled tag replies in the same window.
- `no_reply`, out, 1: one-cycle pulse on LISTEN timeout.
- `reply_cnt`, out, 8: saturating count of clean windows.
- `coll_cnt`, out, 8: saturating count of collided windows.
- `led_sort`, `led_query`, `led_ack`, `led_read`, `led_write`, `led_done`, out, 1 each: status LEDs.

## Operation
- Reset values: all outputs 0 and FSM in IDLE. `rst_n` asserted mid-window aborts the window immediately; counters clear.
- Broadcast: `tag_din[i]` is the registered value of `rd_data & tag_en[i]`.
- Input stage: `tag_dout & tag_en` is registered once to form `t1`. A tag is *active* when its `t1` bit is 1.
- FSM states are IDLE, LISTEN, CAPTURE.
  - IDLE → LISTEN on `cmd_vld` (any code).
  - LISTEN → CAPTURE when any `t1` bit is 1.
    - `owner` latches the lowest active index.
    - If more than one bit is active in that cycle, `collision` is set.
  - LISTEN → IDLE after `LISTEN_MAX` cycles with no activity; `no_reply` pulses.
  - CAPTURE → IDLE after `IDLE_TIMEOUT` consecutive cycles with no edge on `t1[owner]`.
    - If `collision` is 0, increment `reply_cnt` and trigger `led_done`.
    - If `collision` is 1, increment `coll_cnt`.
  - In CAPTURE, any non-owner `t1` bit equal to 1 sets `collision`.
  - `cmd_vld` in LISTEN or CAPTURE restarts LISTEN: timers reload and the current window is discarded without counting.
- `collision` clears on the next `cmd_vld`. `owner` holds its value until the next capture.
- Merge: in CAPTURE, `tag_data` is the registered `t1[owner]`. In IDLE and LISTEN, `tag_data` is 0.
- LEDs:
  - `cmd_vld` with code 0–4 lights the matching LED and loads its counter with `LED_HOLD`. Codes 5–7 light nothing.
  - Each counter decrements every cycle; the LED clears when the counter reaches 0.
  - A re-trigger reloads the counter.
  - Each LED counter is independent.
- Counters saturate at 255.
- A tag whose `tag_en` bit drops mid-window is masked from the next cycle. If it is the owner, the window ends through the timeout.

## Timing
- `rd_data` to `tag_din`: 1 cycle.
- `tag_dout` to `tag_data`: 2 cycles (input register, then output register).
- `cmd_vld` at cycle n: FSM is in LISTEN at n+1 and the LED is high at n+1.
- LED width: an LED is high for exactly `LED_HOLD` cycles after an untouched trigger.
- LISTEN timeout: `no_reply` pulses in cycle n+1+`LISTEN_MAX`, where n is the `cmd_vld` cycle.
- CAPTURE exit: in the cycle after the `IDLE_TIMEOUT`-th quiet cycle, the FSM returns to IDLE and the counter updates.
- Simultaneous `cmd_vld` and timeout expiry: `cmd_vld` wins and nothing is counted.

## Test plan
- Broadcast:
  - Stimulus: `tag_en`=4'b1011, toggle `rd_data`.
  - Response: `tag_din` equals 4'b1011 or 0 one cycle later; `tag_din[2]` stays 0.
- Clean reply:
  - Stimulus: query, then only tag 2 sends 1010.
  - Response: `owner`=2; `tag_data` shows the pattern 2 cycles late; `reply_cnt`=1; `led_done` high for `LED_HOLD`; `collision`=0.
- Collision:
  - Stimulus: tag 1 starts, then tag 3 goes high 5 cycles later.
  - Response: `owner`=1; `collision`=1; `coll_cnt`=1; `reply_cnt` unchanged; next `cmd_vld` clears `collision`.
- Tie:
  - Stimulus: tags 0 and 2 go active in the same cycle.
  - Response: `owner`=0; `collision`=1.
- No reply plus LEDs:
  - Stimulus: write with `LISTEN_MAX`=16 and `LED_HOLD`=8, no tag activity.
  - Response: `no_reply` pulse at cycle n+17; `led_write` high for cycles n+1 to n+8; code 6 lights no LED.
- Abort and reset:
  - Stimulus: `cmd_vld` during CAPTURE; later, `rst_n` low mid-window.
  - Response: the aborted window is not counted; reset returns every output to 0 asynchronously.

Source files
------------

// File: rtl/rfid_link_hub.sv
// Air-link hub: broadcasts the reader line to enabled tags, merges tag replies
// with lowest-index owner arbitration, flags collisions and drives status LEDs.
//
// state   | meaning
// IDLE    | no window open, waiting for a reader command
// LISTEN  | command sent, waiting for the first tag reply
// CAPTURE | owner tag replying, window ends after a quiet stretch
module rfid_link_hub #(
  parameter int NUM_TAGS     = 4,
  parameter int LED_HOLD     = 25_000_000,
  parameter int IDLE_TIMEOUT = 64,
  parameter int LISTEN_MAX   = 4096
) (
  input  logic                                             clk_50m,
  input  logic                                             rst_n,
  input  logic                                             rd_data,
  input  logic                                             cmd_vld,
  input  logic [2:0]                                       cmd_code,
  input  logic [NUM_TAGS-1:0]                              tag_en,
  input  logic [NUM_TAGS-1:0]                              tag_dout,
  output logic [NUM_TAGS-1:0]                              tag_din,
  output logic                                             tag_data,
  output logic [((NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1)-1:0] owner,
  output logic                                             collision,
  output logic                                             no_reply,
  output logic [7:0]                                       reply_cnt,
  output logic [7:0]                                       coll_cnt,
  output logic                                             led_sort,
  output logic                                             led_query,
  output logic                                             led_ack,
  output logic                                             led_read,
  output logic                                             led_write,
  output logic                                             led_done
);

  localparam int OW = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam int LW = (LISTEN_MAX > 1) ? $clog2(LISTEN_MAX) : 1;
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int CW = (LED_HOLD > 1) ? $clog2(LED_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LISTEN  = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_TAGS-1:0]    tag_din_q, tag_din_d;
  logic [NUM_TAGS-1:0]    t1_q, t1_d;
  logic [NUM_TAGS-1:0]    t1_prev_q;
  logic [LW-1:0]          lst_tmr_q, lst_tmr_d;
  logic [IW-1:0]          idl_tmr_q, idl_tmr_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic                   collision_q, collision_d;
  logic                   no_reply_q, no_reply_d;
  logic                   tag_data_q, tag_data_d;
  logic [7:0]             reply_cnt_q, reply_cnt_d;
  logic [7:0]             coll_cnt_q, coll_cnt_d;
  logic [5:0][CW-1:0]     led_cnt_q, led_cnt_d;
  logic [5:0]             led_q, led_d;

  logic [OW-1:0]          low_idx;
  logic                   multi_act;
  logic [NUM_TAGS-1:0]    owner_mask;
  logic                   own_edge;
  logic                   done_trig;
  logic [5:0]             led_trig;

  assign tag_din_d  = rd_data ? tag_en : '0;
  assign t1_d       = tag_dout & tag_en;
  assign multi_act  = |(t1_q & (t1_q - NUM_TAGS'(1)));
  assign owner_mask = NUM_TAGS'(1) << owner_q;
  assign own_edge   = t1_q[owner_q] ^ t1_prev_q[owner_q];

  always_comb begin
    low_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (t1_q[i]) low_idx = OW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    lst_tmr_d   = lst_tmr_q;
    idl_tmr_d   = idl_tmr_q;
    owner_d     = owner_q;
    collision_d = collision_q;
    no_reply_d  = 1'b0;
    reply_cnt_d = reply_cnt_q;
    coll_cnt_d  = coll_cnt_q;
    done_trig   = 1'b0;
    // A new command always wins, even over a timeout expiring in the same cycle.
    if (cmd_vld) begin
      state_d     = LISTEN;
      lst_tmr_d   = LW'(LISTEN_MAX - 1);
      collision_d = 1'b0;
    end else begin
      case (state_q)
        LISTEN: begin
          if (|t1_q) begin
            state_d   = CAPTURE;
            owner_d   = low_idx;
            idl_tmr_d = IW'(IDLE_TIMEOUT - 1);
            if (multi_act) collision_d = 1'b1;
          end else if (lst_tmr_q == '0) begin
            state_d    = IDLE;
            no_reply_d = 1'b1;
          end else begin
            lst_tmr_d = lst_tmr_q - LW'(1);
          end
        end
        CAPTURE: begin
          if (|(t1_q & ~owner_mask)) collision_d = 1'b1;
          if (own_edge) begin
            idl_tmr_d = IW'(IDLE_TIMEOUT - 1);
          end else if (idl_tmr_q == '0) begin
            state_d = IDLE;
            if (collision_d) begin
              coll_cnt_d = (coll_cnt_q == 8'hFF) ? 8'hFF : coll_cnt_q + 8'd1;
            end else begin
              reply_cnt_d = (reply_cnt_q == 8'hFF) ? 8'hFF : reply_cnt_q + 8'd1;
              done_trig   = 1'b1;
            end
          end else begin
            idl_tmr_d = idl_tmr_q - IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Merge follows the next state so the first reply bit is not lost on capture.
  assign tag_data_d = (state_d == CAPTURE) ? t1_q[owner_d] : 1'b0;

  always_comb begin
    led_trig = '0;
    for (int i = 0; i < 5; i++) begin
      led_trig[i] = cmd_vld && (cmd_code == 3'(i));
    end
    led_trig[5] = done_trig;
    for (int i = 0; i < 6; i++) begin
      if (led_trig[i])                led_cnt_d[i] = CW'(LED_HOLD);
      else if (led_cnt_q[i] != '0)    led_cnt_d[i] = led_cnt_q[i] - CW'(1);
      else                            led_cnt_d[i] = '0;
      led_d[i] = (led_cnt_d[i] != '0);
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_din_q   <= '0;
      t1_q        <= '0;
      t1_prev_q   <= '0;
      lst_tmr_q   <= '0;
      idl_tmr_q   <= '0;
      owner_q     <= '0;
      collision_q <= 1'b0;
      no_reply_q  <= 1'b0;
      tag_data_q  <= 1'b0;
      reply_cnt_q <= '0;
      coll_cnt_q  <= '0;
      led_cnt_q   <= '0;
      led_q       <= '0;
    end else begin
      state_q     <= state_d;
      tag_din_q   <= tag_din_d;
      t1_q        <= t1_d;
      t1_prev_q   <= t1_q;
      lst_tmr_q   <= lst_tmr_d;
      idl_tmr_q   <= idl_tmr_d;
      owner_q     <= owner_d;
      collision_q <= collision_d;
      no_reply_q  <= no_reply_d;
      tag_data_q  <= tag_data_d;
      reply_cnt_q <= reply_cnt_d;
      coll_cnt_q  <= coll_cnt_d;
      led_cnt_q   <= led_cnt_d;
      led_q       <= led_d;
    end
  end

  assign tag_din   = tag_din_q;
  assign tag_data  = tag_data_q;
  assign owner     = owner_q;
  assign collision = collision_q;
  assign no_reply  = no_reply_q;
  assign reply_cnt = reply_cnt_q;
  assign coll_cnt  = coll_cnt_q;
  assign led_sort  = led_q[0];
  assign led_query = led_q[1];
  assign led_ack   = led_q[2];
  assign led_read  = led_q[3];
  assign led_write = led_q[4];
  assign led_done  = led_q[5];

endmodule

// File: tb/tb_rfid_link_hub.sv
// Bench for rfid_link_hub: cycle model built from window/timeout rules, checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_rfid_link_hub;

  localparam int NT = 4;
  localparam int LH = 8;
  localparam int IT = 6;
  localparam int LM = 16;

  logic          clk_50m = 1'b0;
  logic          rst_n = 1'b0;
  logic          rd_data = 1'b0;
  logic          cmd_vld = 1'b0;
  logic [2:0]    cmd_code = 3'd0;
  logic [NT-1:0] tag_en = '0;
  logic [NT-1:0] tag_dout = '0;
  logic [NT-1:0] tag_din;
  logic          tag_data;
  logic [1:0]    owner;
  logic          collision, no_reply;
  logic [7:0]    reply_cnt, coll_cnt;
  logic          led_sort, led_query, led_ack, led_read, led_write, led_done;

  rfid_link_hub #(.NUM_TAGS(NT), .LED_HOLD(LH), .IDLE_TIMEOUT(IT), .LISTEN_MAX(LM)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .rd_data(rd_data), .cmd_vld(cmd_vld),
    .cmd_code(cmd_code), .tag_en(tag_en), .tag_dout(tag_dout), .tag_din(tag_din),
    .tag_data(tag_data), .owner(owner), .collision(collision), .no_reply(no_reply),
    .reply_cnt(reply_cnt), .coll_cnt(coll_cnt), .led_sort(led_sort),
    .led_query(led_query), .led_ack(led_ack), .led_read(led_read),
    .led_write(led_write), .led_done(led_done)
  );

  always #10 clk_50m = ~clk_50m;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 waiting for a reply, 2 reply window open.
  int            m_phase, m_elapsed, m_quiet, m_reply, m_ccnt;
  logic [NT-1:0] m_t1, m_t1p, m_din;
  logic          m_data, m_coll, m_nr;
  logic [1:0]    m_own;
  longint        cyc;
  longint        led_until [6];

  task automatic model_reset();
    m_phase = 0; m_elapsed = 0; m_quiet = 0; m_reply = 0; m_ccnt = 0;
    m_t1 = '0; m_t1p = '0; m_din = '0; m_data = 0; m_coll = 0; m_nr = 0; m_own = '0;
    for (int i = 0; i < 6; i++) led_until[i] = -1;
  endtask

  task automatic model_step();
    logic [NT-1:0] nt1;
    nt1 = tag_dout & tag_en;
    cyc++;
    m_nr = 0;
    if (cmd_vld) begin
      m_phase = 1; m_elapsed = 0; m_coll = 0;
      if (cmd_code <= 3'd4) led_until[int'(cmd_code)] = cyc + LH - 1;
    end else if (m_phase == 1) begin
      if (m_t1 != 0) begin
        m_phase = 2;
        m_quiet = 0;
        for (int i = NT - 1; i >= 0; i--) if (m_t1[i]) m_own = 2'(i);
        if ($countones(m_t1) > 1) m_coll = 1;
      end else begin
        m_elapsed++;
        if (m_elapsed == LM) begin m_phase = 0; m_nr = 1; end
      end
    end else if (m_phase == 2) begin
      for (int i = 0; i < NT; i++) if (i != int'(m_own) && m_t1[i]) m_coll = 1;
      if (m_t1[m_own] != m_t1p[m_own]) m_quiet = 0;
      else m_quiet++;
      if (m_quiet == IT) begin
        m_phase = 0;
        if (m_coll) m_ccnt = (m_ccnt < 255) ? m_ccnt + 1 : 255;
        else begin
          m_reply = (m_reply < 255) ? m_reply + 1 : 255;
          led_until[5] = cyc + LH - 1;
        end
      end
    end
    m_data = (m_phase == 2) ? m_t1[m_own] : 1'b0;
    m_din  = rd_data ? tag_en : '0;
    m_t1p  = m_t1;
    m_t1   = nt1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk_50m or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [5:0] exp_led;
    forever begin
      @(negedge clk_50m);
      for (int i = 0; i < 6; i++) exp_led[i] = (cyc <= led_until[i]);
      chk("tag_din",   32'(tag_din),   32'(m_din));
      chk("tag_data",  32'(tag_data),  32'(m_data));
      chk("owner",     32'(owner),     32'(m_own));
      chk("collision", 32'(collision), 32'(m_coll));
      chk("no_reply",  32'(no_reply),  32'(m_nr));
      chk("reply_cnt", 32'(reply_cnt), 32'(m_reply));
      chk("coll_cnt",  32'(coll_cnt),  32'(m_ccnt));
      chk("leds", 32'({led_done, led_write, led_read, led_ack, led_query, led_sort}), 32'(exp_led));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_50m); #1; end
  endtask

  task automatic cmd(input logic [2:0] c);
    cmd_vld = 1'b1; cmd_code = c;
    tick(1);
    cmd_vld = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({tag_din, tag_data, owner, collision, no_reply, led_sort, led_query,
                led_ack, led_read, led_write, led_done}) | 32'(reply_cnt) | 32'(coll_cnt);
  endfunction

  initial begin
    logic [5:0] got;
    int nr_at, led_first, led_last, led_cnt;
    tick(3);
    chk("reset_outs", all_outs(), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Broadcast
    tag_en = 4'b1011;
    rd_data = 1'b1; tick(1);
    chk("bcast_hi", 32'(tag_din), 32'h0000000b);
    rd_data = 1'b0; tick(1);
    chk("bcast_lo", 32'(tag_din), 32'd0);
    for (int i = 0; i < 6; i++) begin rd_data = ~rd_data; tick(1); end
    rd_data = 1'b0;

    // Clean reply from tag 2 with pattern 1010
    tag_en = 4'b1111;
    cmd(3'd1);
    tick(3);
    got = '0;
    for (int i = 0; i < 6; i++) begin
      tag_dout[2] = (i == 0 || i == 2);
      tick(1);
      got = {got[4:0], tag_data};
    end
    chk("clean_pattern", 32'(got), 32'h14);
    tick(IT + 4);
    chk("clean_owner", 32'(owner), 32'd2);
    chk("clean_coll", 32'(collision), 32'd0);
    chk("clean_reply", 32'(reply_cnt), 32'd1);
    chk("clean_led_done", 32'(led_done), 32'd1);

    // Collision: tag 1 first, tag 3 five cycles later
    cmd(3'd1);
    tag_dout[1] = 1'b1; tick(5);
    tag_dout[3] = 1'b1; tick(1);
    tag_dout[3] = 1'b0; tick(1);
    tag_dout[1] = 1'b0;
    tick(IT + 4);
    chk("coll_owner", 32'(owner), 32'd1);
    chk("coll_flag", 32'(collision), 32'd1);
    chk("coll_cnt", 32'(coll_cnt), 32'd1);
    chk("coll_reply", 32'(reply_cnt), 32'd1);
    cmd(3'd0);
    chk("coll_clear", 32'(collision), 32'd0);
    chk("led_sort_on", 32'(led_sort), 32'd1);
    tick(LM + 4);

    // Tie between tags 0 and 2
    cmd(3'd2);
    tag_dout = 4'b0101; tick(2);
    chk("tie_owner", 32'(owner), 32'd0);
    chk("tie_coll", 32'(collision), 32'd1);
    tag_dout = '0;
    tick(IT + 12);

    // No reply with write LED, then reserved code
    cmd(3'd4);
    nr_at = -1; led_first = -1; led_last = -1; led_cnt = 0;
    for (int j = 1; j <= 25; j++) begin
      if (no_reply) nr_at = j;
      if (led_write) begin
        led_cnt++;
        if (led_first < 0) led_first = j;
        led_last = j;
      end
      tick(1);
    end
    chk("noreply_cycle", 32'(nr_at), 32'd17);
    chk("led_write_first", 32'(led_first), 32'd1);
    chk("led_write_last", 32'(led_last), 32'd8);
    chk("led_write_width", 32'(led_cnt), 32'd8);
    cmd(3'd6);
    chk("code6_leds", 32'({led_done, led_write, led_read, led_ack, led_query, led_sort}), 32'd0);
    tick(LM + 4);

    // Abort during capture: window discarded
    cmd(3'd3);
    tag_dout[0] = 1'b1; tick(3);
    cmd_vld = 1'b1; cmd_code = 3'd1; tag_dout[0] = 1'b0; tick(1);
    cmd_vld = 1'b0;
    tick(LM + 4);
    chk("abort_reply", 32'(reply_cnt), 32'd1);
    chk("abort_coll", 32'(coll_cnt), 32'd2);

    // Command coinciding with capture timeout expiry
    cmd(3'd1);
    tag_dout[0] = 1'b1; tick(1);
    tag_dout[0] = 1'b0; tick(1);
    tick(IT);
    cmd(3'd1);
    tick(LM + 4);
    chk("tie_cmd_reply", 32'(reply_cnt), 32'd1);

    // Asynchronous reset mid-window
    cmd(3'd1);
    tag_dout[1] = 1'b1; tick(2);
    rst_n = 1'b0; #2;
    chk("async_reset", all_outs(), 32'd0);
    tick(1);
    tag_dout = '0; rst_n = 1'b1;
    tick(2);

    // Saturation of both statistics counters
    for (int w = 0; w < 260; w++) begin
      cmd(3'd2);
      tag_dout[0] = 1'b1; tick(1);
      tag_dout[0] = 1'b0; tick(IT + 3);
    end
    chk("reply_sat", 32'(reply_cnt), 32'd255);
    for (int w = 0; w < 260; w++) begin
      cmd(3'd2);
      tag_dout = 4'b0101; tick(1);
      tag_dout = '0; tick(IT + 3);
    end
    chk("coll_sat", 32'(coll_cnt), 32'd255);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rd_data  = 1'($urandom_range(0, 1));
      cmd_vld  = ($urandom_range(0, 39) == 0);
      cmd_code = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) tag_en = 4'($urandom);
      if ($urandom_range(0, 99) < 3) tag_dout = '0;
      else for (int t = 0; t < NT; t++) if ($urandom_range(0, 11) == 0) tag_dout[t] = ~tag_dout[t];
      rst_n = ($urandom_range(0, 1499) != 0);
      tick(1);
    end
    cmd_vld = 1'b0; rst_n = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
